// File: rtl/vsync_if.sv
// vsync_if: line strobe, vsync, phase lengths and frame-timing status for vsync_receiver
interface vsync_if;
  logic       LineEnd;
  logic       vsync;
  logic [9:0] SynchPulse;
  logic [9:0] BackPorch;
  logic [9:0] ActiveVideo;
  logic [9:0] FrontPorch;
  logic [9:0] yposition;
  logic       VideoOn;
  logic       Locked;
  logic       FrameDone;
  logic       SyncError;
  logic       ConfigError;
  modport master (
    output LineEnd, vsync, SynchPulse, BackPorch, ActiveVideo, FrontPorch,
    input  yposition, VideoOn, Locked, FrameDone, SyncError, ConfigError
  );
  modport slave (
    input  LineEnd, vsync, SynchPulse, BackPorch, ActiveVideo, FrontPorch,
    output yposition, VideoOn, Locked, FrameDone, SyncError, ConfigError
  );
endinterface

// File: rtl/vsync_receiver.sv
// vsync_receiver: validates vertical frame timing line by line and tracks the active video line
module vsync_receiver #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input logic    clock,
  input logic    reset,
  vsync_if.slave bus
);
  typedef enum logic [2:0] {SEARCH, SYNC, BACK, ACTIVE, FRONT} state_t;
  state_t     state, nstate;
  logic [9:0] count, ncount;
  logic       le_prev, vs_prev, vs, ev, rise, err, done, cfg;
  assign vs   = bus.vsync ^ !VSYNC_ACTIVE_HIGH;
  assign ev   = bus.LineEnd & ~le_prev;
  assign rise = vs & ~vs_prev;
  assign cfg  = ~|bus.SynchPulse | ~|bus.BackPorch | ~|bus.ActiveVideo | ~|bus.FrontPorch;
  assign bus.ConfigError = cfg;
  // Lengths are compared live, so >= keeps a shortened phase from counting past its end
  always_comb begin
    nstate = state;
    ncount = count;
    err    = 1'b0;
    done   = 1'b0;
    if (ev)
      case (state)
        SEARCH: if (rise) begin nstate = SYNC; ncount = 10'd1; end
        SYNC:
          if (count < bus.SynchPulse) begin
            if (vs) ncount = count + 10'd1;
            else err = 1'b1;
          end
          else if (vs) err = 1'b1;
          else begin nstate = BACK; ncount = 10'd1; end
        BACK:
          if (vs) err = 1'b1;
          else if (count >= bus.BackPorch) begin nstate = ACTIVE; ncount = 10'd1; end
          else ncount = count + 10'd1;
        ACTIVE:
          if (vs) err = 1'b1;
          else if (count >= bus.ActiveVideo) begin nstate = FRONT; ncount = 10'd1; end
          else ncount = count + 10'd1;
        FRONT:
          if (count < bus.FrontPorch) begin
            if (vs) err = 1'b1;
            else ncount = count + 10'd1;
          end
          else if (vs) begin nstate = SYNC; ncount = 10'd1; done = 1'b1; end
          else err = 1'b1;
        default: nstate = SEARCH;
      endcase
    // A fresh vsync edge on the failing line restarts the frame without a search
    if (err) begin
      nstate = rise ? SYNC : SEARCH;
      ncount = rise ? 10'd1 : 10'd0;
    end
    if (cfg) begin
      nstate = SEARCH;
      ncount = 10'd0;
      err    = 1'b0;
      done   = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= SEARCH;
      count         <= 10'd0;
      le_prev       <= 1'b1;
      vs_prev       <= 1'b1;
      bus.yposition <= 10'd0;
      bus.VideoOn   <= 1'b0;
      bus.Locked    <= 1'b0;
      bus.FrameDone <= 1'b0;
      bus.SyncError <= 1'b0;
    end else begin
      state         <= nstate;
      count         <= ncount;
      le_prev       <= bus.LineEnd;
      vs_prev       <= ev ? vs : vs_prev;
      bus.yposition <= nstate == ACTIVE ? ncount - 10'd1 : 10'd0;
      bus.VideoOn   <= nstate == ACTIVE;
      bus.Locked    <= (cfg | err) ? 1'b0 : done ? 1'b1 : bus.Locked;
      bus.FrameDone <= done;
      bus.SyncError <= err;
    end
  end
endmodule

// File: tb/tb_vsync_receiver.sv
// tb_vsync_receiver: directed line-by-line checks of vsync_receiver on a 2/3/5/2 12-line frame
module tb_vsync_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vsync_if bus();
  vsync_receiver #(.VSYNC_ACTIVE_HIGH(1'b1)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic von(input int i);
    return i >= 6 && i <= 10;
  endfunction
  function automatic logic [9:0] ypos(input int i);
    return von(i) ? 10'(i - 6) : 10'd0;
  endfunction
  task automatic step(input logic v, input logic evon, input logic [9:0] ey, input logic elk, input logic efd, input logic ese);
    @(negedge clk);
    bus.vsync   = v;
    bus.LineEnd = 1'b1;
    @(negedge clk);
    bus.LineEnd = 1'b0;
    chk("yposition", 32'(bus.yposition), 32'(ey));
    chk("VideoOn", 32'(bus.VideoOn), 32'(evon));
    chk("Locked", 32'(bus.Locked), 32'(elk));
    chk("FrameDone", 32'(bus.FrameDone), 32'(efd));
    chk("SyncError", 32'(bus.SyncError), 32'(ese));
    @(negedge clk);
    chk("FrameDone_clear", 32'(bus.FrameDone), 32'd0);
    chk("SyncError_clear", 32'(bus.SyncError), 32'd0);
    chk("yposition_hold", 32'(bus.yposition), 32'(ey));
    repeat (3) @(negedge clk);
  endtask
  task automatic lines(input int first, input int last, input logic lk, input logic fd);
    for (int i = first; i <= last; i++)
      step(i <= 2, von(i), ypos(i), lk, fd && i == 1, 1'b0);
  endtask
  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) step(v, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic reset_check(input logic v);
    @(negedge clk);
    bus.vsync = v;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_yposition", 32'(bus.yposition), 32'd0);
    chk("rst_VideoOn", 32'(bus.VideoOn), 32'd0);
    chk("rst_Locked", 32'(bus.Locked), 32'd0);
    chk("rst_FrameDone", 32'(bus.FrameDone), 32'd0);
    chk("rst_SyncError", 32'(bus.SyncError), 32'd0);
    rst = 1'b0;
  endtask
  initial begin
    bus.LineEnd     = 1'b0;
    bus.vsync       = 1'b0;
    bus.SynchPulse  = 10'd2;
    bus.BackPorch   = 10'd3;
    bus.ActiveVideo = 10'd5;
    bus.FrontPorch  = 10'd2;
    reset_check(1'b0);
    chk("ConfigError_ok", 32'(bus.ConfigError), 32'd0);
    idle(3, 1'b0);
    lines(1, 12, 1'b0, 1'b0);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 10, 1'b1, 1'b1);
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    lines(2, 12, 1'b0, 1'b0);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b0);
    reset_check(1'b1);
    idle(2, 1'b1);
    idle(10, 1'b0);
    lines(1, 12, 1'b0, 1'b0);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 2, 1'b1, 1'b1);
    @(negedge clk);
    bus.ActiveVideo = 10'd0;
    #1;
    chk("ConfigError_set", 32'(bus.ConfigError), 32'd1);
    @(negedge clk);
    chk("cfg_Locked_drop", 32'(bus.Locked), 32'd0);
    idle(3, 1'b0);
    bus.ActiveVideo = 10'd5;
    #1;
    chk("ConfigError_clear", 32'(bus.ConfigError), 32'd0);
    lines(1, 12, 1'b0, 1'b0);
    lines(1, 12, 1'b1, 1'b1);
    lines(1, 8, 1'b1, 1'b1);
    @(negedge clk);
    bus.LineEnd = 1'b1;
    bus.vsync   = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("midrst_yposition", 32'(bus.yposition), 32'd0);
    chk("midrst_VideoOn", 32'(bus.VideoOn), 32'd0);
    chk("midrst_Locked", 32'(bus.Locked), 32'd0);
    chk("midrst_FrameDone", 32'(bus.FrameDone), 32'd0);
    chk("midrst_SyncError", 32'(bus.SyncError), 32'd0);
    rst         = 1'b0;
    bus.LineEnd = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vsync_receiver.md
VSYNC_RECEIVER -- requirements
Module: vsync_receiver

Interface
REQ-001 SHALL have parameter VSYNC_ACTIVE_HIGH, default 1; 1 = vsync asserted high, 0 = vsync asserted low (input XORed before all logic).
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 LineEnd  input  1  line strobe, synchronous to clock; each rising edge is one line event.
REQ-006 vsync  input  1  vertical sync under test, synchronous to clock.
REQ-007 SynchPulse, BackPorch, ActiveVideo, FrontPorch  input  10 each  expected phase lengths in lines.
REQ-008 yposition  output  10  active line index, 0 outside ACTIVE.
REQ-009 VideoOn  output  1  high while state is ACTIVE.
REQ-010 Locked  output  1  high after one fully validated frame, until an error or reset.
REQ-011 FrameDone  output  1  one-cycle pulse at each validated frame end.
REQ-012 SyncError  output  1  one-cycle pulse on any timing violation.
REQ-013 ConfigError  output  1  combinational: any of the four length inputs equals 0.

Function
REQ-014 Line event SHALL be LineEnd==1 with registered LineEndPrev==0; all outputs are registered and update at the end of the event cycle (1-cycle latency).
REQ-015 vsync SHALL be sampled only on line events; VsPrev holds the sample from the previous event.
REQ-016 States SHALL be SEARCH, SYNC, BACK, ACTIVE, FRONT; PhaseCount (10 bit) is the 1-based line index within the current phase.
REQ-017 SEARCH: on an event with vsync=1 and VsPrev=0, go to SYNC with PhaseCount=1; otherwise stay.
REQ-018 SYNC: on an event with PhaseCount<SynchPulse, vsync=1 increments PhaseCount and vsync=0 is an error. With PhaseCount==SynchPulse, vsync=0 goes to BACK with PhaseCount=1 and vsync=1 is an error.
REQ-019 BACK: vsync=1 is an error. Else if PhaseCount==BackPorch, go to ACTIVE with PhaseCount=1. Else increment.
REQ-020 ACTIVE: vsync=1 is an error. Else if PhaseCount==ActiveVideo, go to FRONT with PhaseCount=1. Else increment. yposition is PhaseCount-1.
REQ-021 FRONT: if PhaseCount<FrontPorch, vsync=0 increments and vsync=1 is an error. With PhaseCount==FrontPorch, vsync=1 goes to SYNC with PhaseCount=1, pulses FrameDone and sets Locked; vsync=0 is an error.
REQ-022 On an error, SHALL pulse SyncError and clear Locked. If vsync=1 and VsPrev=0 at that event, go to SYNC with PhaseCount=1 (immediate reacquire); otherwise go to SEARCH.
REQ-023 While ConfigError=1, SHALL force SEARCH, Locked=0 and suppress SyncError and FrameDone.
REQ-024 Length inputs SHALL be compared live; a change mid-frame is judged against the new values.
REQ-025 Between line events, state, counters and outputs SHALL hold, except that FrameDone and SyncError return to 0 after one cycle.

Reset
REQ-026 reset=1 SHALL set state=SEARCH, PhaseCount=0, LineEndPrev=1, VsPrev=1, yposition=0, VideoOn=0, Locked=0, FrameDone=0, SyncError=0.
REQ-027 reset SHALL override any line event in the same cycle; reset mid-frame discards the frame, and reacquisition needs a fresh vsync assertion edge.

Verification (SynchPulse=2, BackPorch=3, ActiveVideo=5, FrontPorch=2; 12-line frame)
REQ-028 Reset held, then released with LineEnd toggling every 6 clocks and vsync=0 -> all outputs 0, state stays SEARCH.
REQ-029 Nominal frames (vsync high 2 lines, low 10) -> yposition 0..4 with VideoOn=1 on frame lines 6-10. FrameDone pulses at the line 13 event. Locked=1 from then on, with no SyncError over 3 frames.
REQ-030 vsync high for only 1 line -> SyncError pulse on the line 2 event, Locked=0, state SEARCH, and no VideoOn in that frame.
REQ-031 Locked, then an 11-line frame (vsync rises at FRONT line 1) -> SyncError pulse, Locked=0, immediate SYNC reacquire, and Locked=1 again after the next correct 12-line frame.
REQ-032 vsync already high at reset release -> no acquisition until vsync falls and rises again on a later line event.
REQ-033 ActiveVideo=0 while locked -> ConfigError=1, Locked=0, SEARCH, no SyncError. On restoring 5, relock after one full frame. Separately, reset asserted at yposition=2 -> all outputs at their reset values next cycle.
